// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine back end: sequencer states,
// coin encodings with their dollar values, and the product count.
package vending_pkg;

  localparam int N_PROD = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    VEND,
    VEND_GAP,
    COIN,
    COIN_GAP,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;

  localparam logic [3:0] COIN_1_VAL  = 4'd1;
  localparam logic [3:0] COIN_5_VAL  = 4'd5;
  localparam logic [3:0] COIN_10_VAL = 4'd10;

endpackage

// File: rtl/coin_select.sv
// Greedy change picker: largest coin that still fits in the owed amount.
module coin_select
  import vending_pkg::*;
(
  input  logic [7:0] change_left,
  output logic [1:0] coin_sel,
  output logic [3:0] coin_value
);

  always_comb begin
    coin_sel   = COIN_1;
    coin_value = COIN_1_VAL;
    if (change_left >= 8'd10) begin
      coin_sel   = COIN_10;
      coin_value = COIN_10_VAL;
    end else if (change_left >= 8'd5) begin
      coin_sel   = COIN_5;
      coin_value = COIN_5_VAL;
    end
  end

endmodule

// File: rtl/dispense_sequencer.sv
// Back-end sequencer: stock check, one motor pulse per unit, then greedy
// change payout over req/ack handshakes, with ack timeouts leading to FAULT.
module dispense_sequencer #(
  parameter int N_PROD      = vending_pkg::N_PROD,
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 9,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        product_id,
  input  logic [3:0]        quantity,
  input  logic [7:0]        price_total,
  input  logic [7:0]        paid,
  input  logic              restock,
  output logic              motor_req,
  input  logic              motor_ack,
  output logic [2:0]        motor_sel,
  output logic              coin_req,
  input  logic              coin_ack,
  output logic [1:0]        coin_sel,
  output logic              busy,
  output logic              done,
  output logic              refunded,
  output logic              fault,
  output logic [7:0]        change_left,
  output logic [N_PROD-1:0] stock_empty
);

  import vending_pkg::*;

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  logic [2:0]         prod_r;
  logic [3:0]         qty_r;
  logic [7:0]         price_r;
  logic [7:0]         paid_r;
  logic [3:0]         units_left;
  logic [3:0]         coin_val_r;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [STOCK_W-1:0] stock [N_PROD];

  logic [STOCK_W-1:0] stock_sel;
  logic               prod_valid;
  logic               refund_chk;
  logic [7:0]         check_change;
  logic [7:0]         coin_src;
  logic [1:0]         next_coin_sel;
  logic [3:0]         next_coin_val;
  logic               tmo_hit;

  // Stock of the latched product; an out-of-range id simply matches nothing.
  always_comb begin
    stock_sel  = '0;
    prod_valid = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (prod_r == 3'(i + 1)) begin
        prod_valid = 1'b1;
        stock_sel  = stock[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_PROD; i++) begin
      stock_empty[i] = (stock[i] == '0);
    end
  end

  assign refund_chk   = !prod_valid || (qty_r == 4'd0) || (paid_r < price_r) ||
                        (32'(stock_sel) < 32'(qty_r));
  assign check_change = refund_chk ? paid_r : (paid_r - price_r);
  // The first coin is picked while change_left is still being loaded.
  assign coin_src     = (state == CHECK) ? check_change : change_left;
  assign tmo_hit      = (32'(tmo_cnt) >= ACK_TIMEOUT - 1);

  coin_select u_coin_select (
    .change_left (coin_src),
    .coin_sel    (next_coin_sel),
    .coin_value  (next_coin_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prod_r      <= '0;
      qty_r       <= '0;
      price_r     <= '0;
      paid_r      <= '0;
      units_left  <= '0;
      coin_val_r  <= '0;
      tmo_cnt     <= '0;
      motor_req   <= 1'b0;
      motor_sel   <= '0;
      coin_req    <= 1'b0;
      coin_sel    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      refunded    <= 1'b0;
      fault       <= 1'b0;
      change_left <= '0;
      for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      done <= 1'b0;
      if (32'(tmo_cnt) < ACK_TIMEOUT) tmo_cnt <= tmo_cnt + TMO_W'(1);

      unique case (state)
        IDLE: begin
          if (start) begin
            prod_r  <= product_id;
            qty_r   <= quantity;
            price_r <= price_total;
            paid_r  <= paid;
            busy    <= 1'b1;
            tmo_cnt <= '0;
            state   <= CHECK;
          end else if (restock) begin
            for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(INIT_STOCK);
          end
        end

        CHECK: begin
          tmo_cnt     <= '0;
          refunded    <= refund_chk;
          change_left <= check_change;
          units_left  <= qty_r;
          motor_sel   <= prod_r;
          if (!refund_chk) begin
            motor_req <= 1'b1;
            state     <= VEND;
          end else if (paid_r != 8'd0) begin
            coin_req   <= 1'b1;
            coin_sel   <= next_coin_sel;
            coin_val_r <= next_coin_val;
            state      <= COIN;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        VEND: begin
          if (motor_ack) begin
            for (int i = 0; i < N_PROD; i++) begin
              if (prod_r == 3'(i + 1)) stock[i] <= stock[i] - STOCK_W'(1);
            end
            units_left <= units_left - 4'd1;
            motor_req  <= 1'b0;
            tmo_cnt    <= '0;
            state      <= VEND_GAP;
          end else if (tmo_hit) begin
            motor_req <= 1'b0;
            fault     <= 1'b1;
            tmo_cnt   <= '0;
            state     <= FAULT;
          end
        end

        VEND_GAP: begin
          if (!motor_ack) begin
            tmo_cnt <= '0;
            if (units_left != 4'd0) begin
              motor_req <= 1'b1;
              state     <= VEND;
            end else if (change_left != 8'd0) begin
              coin_req   <= 1'b1;
              coin_sel   <= next_coin_sel;
              coin_val_r <= next_coin_val;
              state      <= COIN;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end else if (tmo_hit) begin
            fault   <= 1'b1;
            tmo_cnt <= '0;
            state   <= FAULT;
          end
        end

        COIN: begin
          if (coin_ack) begin
            change_left <= change_left - {4'd0, coin_val_r};
            coin_req    <= 1'b0;
            tmo_cnt     <= '0;
            state       <= COIN_GAP;
          end else if (tmo_hit) begin
            coin_req <= 1'b0;
            fault    <= 1'b1;
            tmo_cnt  <= '0;
            state    <= FAULT;
          end
        end

        COIN_GAP: begin
          if (!coin_ack) begin
            tmo_cnt <= '0;
            if (change_left != 8'd0) begin
              coin_req   <= 1'b1;
              coin_sel   <= next_coin_sel;
              coin_val_r <= next_coin_val;
              state      <= COIN;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end else if (tmo_hit) begin
            fault   <= 1'b1;
            tmo_cnt <= '0;
            state   <= FAULT;
          end
        end

        DONE: begin
          tmo_cnt <= '0;
          state   <= IDLE;
        end

        FAULT: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: a vector table of whole transactions
// plus hand sequences for latency, stock exhaustion, reset, restock and fault.
module tb_dispense_sequencer;

  localparam int NP = 5;
  localparam int NV = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    product_id;
  logic [3:0]    quantity;
  logic [7:0]    price_total;
  logic [7:0]    paid;
  logic          restock;
  logic          motor_req;
  logic          motor_ack = 1'b0;
  logic [2:0]    motor_sel;
  logic          coin_req;
  logic          coin_ack = 1'b0;
  logic [1:0]    coin_sel;
  logic          busy;
  logic          done;
  logic          refunded;
  logic          fault;
  logic [7:0]    change_left;
  logic [NP-1:0] stock_empty;

  typedef struct {
    logic [2:0] prod;
    logic [3:0] qty;
    logic [7:0] price;
    logic [7:0] paid;
    logic       exp_ref;
    int         exp_motors;
    int         n10;
    int         n5;
    int         n1;
    logic [4:0] exp_empty;
  } vec_t;

  vec_t       vecs [NV];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       motor_en   = 1'b1;
  logic       motor_hold = 1'b0;
  logic       coin_en    = 1'b1;
  logic [2:0] motor_log [$];
  logic [1:0] coin_log  [$];
  logic [1:0] exp_coins [$];
  logic       seen;
  int         cyc;
  int         cnt;
  int         done_cnt;

  always #5 clk = ~clk;

  dispense_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .product_id  (product_id),
    .quantity    (quantity),
    .price_total (price_total),
    .paid        (paid),
    .restock     (restock),
    .motor_req   (motor_req),
    .motor_ack   (motor_ack),
    .motor_sel   (motor_sel),
    .coin_req    (coin_req),
    .coin_ack    (coin_ack),
    .coin_sel    (coin_sel),
    .busy        (busy),
    .done        (done),
    .refunded    (refunded),
    .fault       (fault),
    .change_left (change_left),
    .stock_empty (stock_empty)
  );

  // Half-cycle responders that also log each new request they see.
  always @(negedge clk) begin
    if (motor_req && !motor_ack) motor_log.push_back(motor_sel);
    if (coin_req && !coin_ack) coin_log.push_back(coin_sel);
    if (!motor_hold) motor_ack = motor_en & motor_req;
    coin_ack = coin_en & coin_req;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] p, input logic [3:0] q,
                               input logic [7:0] pr, input logic [7:0] pd,
                               input logic rs);
    motor_log.delete();
    coin_log.delete();
    @(negedge clk);
    product_id  = p;
    quantity    = q;
    price_total = pr;
    paid        = pd;
    restock     = rs;
    start       = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    restock = 1'b0;
  endtask

  task automatic waitDone(input int budget, output logic got, output int cycles);
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) got = 1'b1;
    end
  endtask

  initial begin
    vecs[0]  = '{3'd1, 4'd2, 8'd12,  8'd20,  1'b0, 2, 0,  1, 3, 5'b00000};
    vecs[1]  = '{3'd2, 4'd1, 8'd10,  8'd5,   1'b1, 0, 0,  1, 0, 5'b00000};
    vecs[2]  = '{3'd0, 4'd1, 8'd1,   8'd1,   1'b1, 0, 0,  0, 1, 5'b00000};
    vecs[3]  = '{3'd6, 4'd1, 8'd1,   8'd0,   1'b1, 0, 0,  0, 0, 5'b00000};
    vecs[4]  = '{3'd4, 4'd0, 8'd0,   8'd16,  1'b1, 0, 1,  1, 1, 5'b00000};
    vecs[5]  = '{3'd5, 4'd3, 8'd6,   8'd6,   1'b0, 3, 0,  0, 0, 5'b00000};
    vecs[6]  = '{3'd1, 4'd8, 8'd8,   8'd8,   1'b1, 0, 0,  1, 3, 5'b00000};
    vecs[7]  = '{3'd2, 4'd9, 8'd255, 8'd255, 1'b0, 9, 0,  0, 0, 5'b00010};
    vecs[8]  = '{3'd2, 4'd1, 8'd1,   8'd3,   1'b1, 0, 0,  0, 3, 5'b00010};
    vecs[9]  = '{3'd1, 4'd1, 8'd0,   8'd255, 1'b0, 1, 25, 1, 0, 5'b00010};
    vecs[10] = '{3'd7, 4'd1, 8'd0,   8'd10,  1'b1, 0, 1,  0, 0, 5'b00010};

    reset = 1'b1; start = 1'b0; restock = 1'b0;
    product_id = '0; quantity = '0; price_total = '0; paid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset motor_req", motor_req, 0);
    checkOutput("reset coin_req", coin_req, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset fault", fault, 0);
    checkOutput("reset change_left", change_left, 0);
    checkOutput("reset stock_empty", stock_empty, 0);

    // Latency: CHECK the cycle after start, motor_req the cycle after that.
    applyStimulus(3'd1, 4'd1, 8'd1, 8'd1, 1'b0);
    checkOutput("latency busy in CHECK", busy, 1);
    checkOutput("latency no req in CHECK", motor_req, 0);
    @(negedge clk);
    checkOutput("latency motor_req", motor_req, 1);
    checkOutput("latency motor_sel", motor_sel, 1);
    waitDone(100, seen, cyc);
    checkOutput("latency done", seen, 1);
    checkOutput("latency busy at done", busy, 0);

    for (int v = 0; v < NV; v++) begin
      applyStimulus(vecs[v].prod, vecs[v].qty, vecs[v].price, vecs[v].paid, 1'b0);
      waitDone(3000, seen, cyc);
      checkOutput($sformatf("vec%0d done", v), seen, 1);
      checkOutput($sformatf("vec%0d refunded", v), refunded, vecs[v].exp_ref);
      checkOutput($sformatf("vec%0d busy", v), busy, 0);
      checkOutput($sformatf("vec%0d change_left", v), change_left, 0);
      checkOutput($sformatf("vec%0d motor count", v), motor_log.size(), vecs[v].exp_motors);
      foreach (motor_log[k])
        checkOutput($sformatf("vec%0d motor_sel%0d", v, k), motor_log[k], vecs[v].prod);
      exp_coins.delete();
      repeat (vecs[v].n10) exp_coins.push_back(2'd2);
      repeat (vecs[v].n5)  exp_coins.push_back(2'd1);
      repeat (vecs[v].n1)  exp_coins.push_back(2'd0);
      checkOutput($sformatf("vec%0d coin count", v), coin_log.size(), exp_coins.size());
      for (int k = 0; k < exp_coins.size(); k++)
        checkOutput($sformatf("vec%0d coin%0d", v, k),
                    (k < coin_log.size()) ? 32'(coin_log[k]) : 32'd3, exp_coins[k]);
      checkOutput($sformatf("vec%0d stock_empty", v), stock_empty, vecs[v].exp_empty);
    end

    // Stock exhaustion on product 3, then a refund in 10 and 5.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset reload", stock_empty, 0);
    for (int n = 0; n < 9; n++) begin
      applyStimulus(3'd3, 4'd1, 8'd1, 8'd1, 1'b0);
      waitDone(100, seen, cyc);
    end
    checkOutput("exhaust stock_empty", stock_empty, 5'b00100);
    applyStimulus(3'd3, 4'd1, 8'd1, 8'd15, 1'b0);
    waitDone(200, seen, cyc);
    checkOutput("exhaust refunded", refunded, 1);
    checkOutput("exhaust coin count", coin_log.size(), 2);
    checkOutput("exhaust coin0", coin_log[0], 2);
    checkOutput("exhaust coin1", coin_log[1], 1);

    // start with restock: transaction runs, restock is dropped.
    applyStimulus(3'd1, 4'd1, 8'd1, 8'd1, 1'b1);
    waitDone(100, seen, cyc);
    checkOutput("start+restock refunded", refunded, 0);
    checkOutput("start+restock motors", motor_log.size(), 1);
    checkOutput("start+restock stock", stock_empty, 5'b00100);

    // start while done is high is ignored.
    product_id = 3'd1; quantity = 4'd1; price_total = 8'd1; paid = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start in done busy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("start in done motor_req", motor_req, 0);
    checkOutput("start in done still idle", busy, 0);

    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    checkOutput("restock reload", stock_empty, 0);

    // Reset in VEND_GAP after draining product 5.
    applyStimulus(3'd5, 4'd9, 8'd9, 8'd9, 1'b0);
    waitDone(200, seen, cyc);
    checkOutput("drain stock_empty", stock_empty, 5'b10000);
    applyStimulus(3'd2, 4'd2, 8'd2, 8'd2, 1'b0);
    cnt = 0;
    while (!motor_ack && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    motor_hold = 1'b1;
    @(negedge clk);
    checkOutput("gap motor_req low", motor_req, 0);
    checkOutput("gap busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    motor_hold = 1'b0;
    checkOutput("gap reset busy", busy, 0);
    checkOutput("gap reset motor_req", motor_req, 0);
    checkOutput("gap reset stock", stock_empty, 0);
    done_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("gap reset no done", done_cnt, 0);

    // Hopper never acks: fault after ACK_TIMEOUT cycles of coin_req.
    coin_en = 1'b0;
    applyStimulus(3'd1, 4'd1, 8'd10, 8'd5, 1'b0);
    cnt = 0;
    while (!coin_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("fault coin_req seen", coin_req, 1);
    cnt = 0;
    while (!fault && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("fault delay", cnt, 255);
    checkOutput("fault coin_req dropped", coin_req, 0);
    checkOutput("fault change frozen", change_left, 5);
    applyStimulus(3'd1, 4'd1, 8'd1, 8'd1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("fault sticky", fault, 1);
    checkOutput("fault start ignored", motor_req, 0);
    checkOutput("fault busy", busy, 1);
    reset = 1'b1;
    coin_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("fault cleared by reset", fault, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
